pll_lock_supervisor: RTL

Sequences the reset and lock-acquisition of a general-purpose PLL and gates the downstream system reset on a verified, stable lock. Runs in the PLL reference-clock domain and sits between the board reset and the PLL `rst` / `locked` pins. It drives a clean synchronous reset to the cores clocked from the PLL outputs, and retries or reports failure when lock is not achieved.

---
 rtl/pll_lock_supervisor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock, then releases sys_rst.
// Optional macro PLL_SUPERVISOR_AUTORECOVER_EN: loss of lock in RUN restarts acquisition instead of failing.
module pll_lock_supervisor #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       req_restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt
);

    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_END     = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_cnt_q, retry_cnt_d;
    logic             lock_meta_q, lock_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             enter;

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        enter       = 1'b0;

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_END) begin
                    state_d = ST_WAIT_LOCK;
                    enter   = 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    enter   = 1'b1;
                end else if (cnt_q == TIMEOUT_END) begin
                    enter = 1'b1;
                    if (retry_cnt_q == RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d     = ST_RESET_PLL;
                        retry_cnt_d = retry_cnt_q + 4'd1;
                    end
                end
            end
            ST_STABLE: begin
                // A glitch only restarts the timeout window; no retry is charged.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    enter   = 1'b1;
                end else if (cnt_q == STABLE_END) begin
                    state_d = ST_RUN;
                    enter   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    enter = 1'b1;
`ifdef PLL_SUPERVISOR_AUTORECOVER_EN
                    state_d     = ST_RESET_PLL;
                    retry_cnt_d = 4'd0;
`else
                    state_d = ST_FAIL;
`endif
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RESET_PLL;
                enter   = 1'b1;
            end
        endcase

        if (req_restart) begin
            state_d     = ST_RESET_PLL;
            retry_cnt_d = 4'd0;
            enter       = 1'b1;
        end

        // The entry edge counts as the first cycle in the new state, so a state
        // entered on edge E with limit N leaves on edge E+N.
        cnt_d = cnt_q;
        if (enter) begin
            cnt_d = CNT_ONE;
        end else if (state_q == ST_RESET_PLL || state_q == ST_WAIT_LOCK
                     || state_q == ST_STABLE) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retry_cnt_q <= 4'd0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_cnt_q <= retry_cnt_d;
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;

endmodule
